aes_stim_gen: RTL and testbench

//  Parametrised on-FPGA stimulus generator for AES-128 chip bring-up.

---
 rtl/aes_stim_pkg.sv | 27 ++
 rtl/aes_stim_div.sv | 30 +++
 rtl/aes_stim_gen.sv | 152 +++++++++++++++
 tb/tb_aes_stim_gen.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_stim_pkg.sv
// Shared types and constants for the AES-128 bring-up stimulus generator.
package aes_stim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    VECTOR = 2'd0,
    INCR   = 2'd1,
    ONES   = 2'd2,
    LFSR   = 2'd3
  } mode_e;

  localparam int unsigned BYTES_PER_BLK = 16;
  localparam logic [15:0] LFSR_SEED     = 16'hACE1;
  // Taps 16,14,13,11 counted from the output end: bits 0,2,3,5 of a right-shifting register
  localparam logic [15:0] LFSR_TAPS     = 16'h002D;

  // One Fibonacci step: shift right, feedback into the MSB
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/aes_stim_div.sv
// Clock-enable divider: strobes once every DIV enabled cycles; clr restarts the count.
module aes_stim_div #(
  parameter int unsigned DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic strobe
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  assign strobe = en && (cnt_q == LAST);

  // Count 0..DIV-1 while enabled, wrapping on the strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= strobe ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/aes_stim_gen.sv
// Stimulus generator streaming key/plaintext byte frames with toggle-valid signalling.
// Optional feature: define AES_STIM_LFSR_EN to make mode 3 a 16-bit LFSR pattern;
// otherwise mode 3 behaves as mode 0 and no LFSR state exists.
module aes_stim_gen
  import aes_stim_pkg::*;
#(
  parameter int unsigned DIV        = 16,
  parameter int unsigned NUM_BLOCKS = 4,
  parameter int unsigned DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              repeat_en,
  input  logic [1:0]        cfg_mode,
  input  logic              cfg_cu,
  input  logic              cfg_id,
  output logic              test_cu,
  output logic              test_id,
  output logic [DATA_W-1:0] test_data,
  output logic              test_valid,
  output logic              busy,
  output logic              done
);

  localparam int unsigned NUM_BYTES = NUM_BLOCKS * BYTES_PER_BLK;
  localparam int unsigned IDX_W     = $clog2(NUM_BYTES);
  localparam int unsigned BLK_SHIFT = $clog2(BYTES_PER_BLK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  state_e            state_q;
  mode_e             mode_q;
  logic              rep_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  blk;
  logic [DATA_W-1:0] pattern;
  logic              start_take;
  logic              restart;
  logic              div_clr;
  logic              div_en;
  logic              strobe;

  // Abort dominates both start and the strobe
  assign start_take = start && !abort && (state_q == IDLE);
  assign restart    = (state_q == DONE) && rep_q && !abort;
  assign div_clr    = abort || start_take || (state_q == DONE);
  assign div_en     = (state_q == SEND) && !abort;
  assign blk        = idx_q >> BLK_SHIFT;

  aes_stim_div #(
    .DIV (DIV)
  ) u_div (
    .clk    (clk),
    .rst    (rst),
    .clr    (div_clr),
    .en     (div_en),
    .strobe (strobe)
  );

`ifdef AES_STIM_LFSR_EN
  logic [15:0] lfsr_q;

  // Seed reloads at every frame start so repeated frames are identical
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= LFSR_SEED;
    end else if (start_take || restart) begin
      lfsr_q <= LFSR_SEED;
    end else if (strobe) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end
`endif

  // Byte pattern for the current index
  always_comb begin
    pattern = '0;
    case (mode_q)
      INCR:    pattern = DATA_W'(idx_q);
      ONES:    pattern = '1;
`ifdef AES_STIM_LFSR_EN
      LFSR:    pattern = DATA_W'(lfsr_q);
`endif
      default: pattern = (blk == IDX_W'(1)) ? DATA_W'(1) : '0;
    endcase
  end

  // Frame FSM with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      mode_q     <= VECTOR;
      rep_q      <= 1'b0;
      idx_q      <= '0;
      test_cu    <= 1'b0;
      test_id    <= 1'b1;
      test_data  <= '0;
      test_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (abort) begin
      // Data, valid level, cu and id keep their last values
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SEND;
            mode_q  <= mode_e'(cfg_mode);
            rep_q   <= repeat_en;
            test_cu <= cfg_cu;
            test_id <= cfg_id;
            idx_q   <= '0;
            busy    <= 1'b1;
          end
        end
        SEND: begin
          if (strobe) begin
            test_data  <= pattern;
            test_valid <= ~test_valid;
            if (idx_q == LAST_IDX) begin
              state_q <= DONE;
              idx_q   <= '0;
              done    <= 1'b1;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          idx_q <= '0;
          if (rep_q) begin
            state_q <= SEND;
          end else begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_stim_gen.sv
// Scoreboard bench for aes_stim_gen: instance a uses default parameters, instance b
// uses DIV=1, NUM_BLOCKS=20. Expected bytes and their arrival cycles are queued at
// start; monitors pop on every test_valid toggle and on every done pulse.
module tb_aes_stim_gen;

  localparam int DIV_A = 16;
  localparam int N_A   = 64;
  localparam int DIV_B = 1;
  localparam int N_B   = 320;

  typedef struct {
    logic [7:0] data;
    int         at;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  int         cyc = 0;

  logic       start_a = 0, abort_a = 0, rep_a = 0, cu_a = 0, id_a = 0;
  logic [1:0] mode_a = 0;
  logic       tcu_a, tid_a, tv_a, busy_a, done_a;
  logic [7:0] td_a;

  logic       start_b = 0, abort_b = 0, rep_b = 0, cu_b = 0, id_b = 0;
  logic [1:0] mode_b = 0;
  logic       tcu_b, tid_b, tv_b, busy_b, done_b;
  logic [7:0] td_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int   dq_a[$];
  int   dq_b[$];

  int   n_vec = 0;
  int   n_bad = 0;
  logic lvl_a = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_stim_gen u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .repeat_en(rep_a),
    .cfg_mode(mode_a), .cfg_cu(cu_a), .cfg_id(id_a), .test_cu(tcu_a), .test_id(tid_a),
    .test_data(td_a), .test_valid(tv_a), .busy(busy_a), .done(done_a)
  );

  aes_stim_gen #(.DIV(DIV_B), .NUM_BLOCKS(20), .DATA_W(8)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .repeat_en(rep_b),
    .cfg_mode(mode_b), .cfg_cu(cu_b), .cfg_id(id_b), .test_cu(tcu_b), .test_id(tid_b),
    .test_data(td_b), .test_valid(tv_b), .busy(busy_b), .done(done_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int mode, input int idx, input logic [15:0] l);
    if (mode == 1) return 8'(idx);
    if (mode == 2) return 8'hFF;
`ifdef AES_STIM_LFSR_EN
    if (mode == 3) return l[7:0];
`endif
    return (idx / 16 == 1) ? 8'h01 : 8'h00;
  endfunction

  // Queue nbytes expected bytes of a frame whose start edge is 'base'
  task automatic push_frame(input int which, input int mode, input int base, input int div,
                            input int nfull, input int nbytes, input bit with_done);
    exp_t e;
    logic [15:0] l;
    l = 16'hACE1;
    for (int k = 0; k < nbytes; k++) begin
      e.data = exp_byte(mode, k, l);
      e.at   = base + (k + 1) * div;
      if (which == 0) q_a.push_back(e);
      else q_b.push_back(e);
      l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    end
    if (with_done) begin
      if (which == 0) dq_a.push_back(base + nfull * div);
      else dq_b.push_back(base + nfull * div);
    end
  endtask

  task automatic mon(input int which, input string nm, input logic v, input logic pv,
                     input logic [7:0] d, input logic dn);
    exp_t e;
    int   dc;
    if (v !== pv) begin
      if ((which == 0 && q_a.size() == 0) || (which == 1 && q_b.size() == 0)) begin
        n_vec++;
        n_bad++;
        $display("FAIL %s_toggle: unexpected toggle at cycle %0d data %02h, expected none",
                 nm, cyc, d);
      end else begin
        if (which == 0) e = q_a.pop_front();
        else e = q_b.pop_front();
        check({nm, "_data"}, 32'(d), 32'(e.data));
        check({nm, "_time"}, 32'(cyc), 32'(e.at));
      end
    end
    if (dn !== 1'b0) begin
      if ((which == 0 && dq_a.size() == 0) || (which == 1 && dq_b.size() == 0)) begin
        n_vec++;
        n_bad++;
        $display("FAIL %s_done: unexpected done=%b at cycle %0d, expected 0", nm, dn, cyc);
      end else begin
        if (which == 0) dc = dq_a.pop_front();
        else dc = dq_b.pop_front();
        check({nm, "_done_time"}, 32'(cyc), 32'(dc));
      end
    end
  endtask

  initial begin
    logic pv;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) mon(0, "a", tv_a, pv, td_a, done_a);
      pv = tv_a;
    end
  end

  initial begin
    logic pv;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) mon(1, "b", tv_b, pv, td_b, done_b);
      pv = tv_b;
    end
  end

  // Pulse start on instance a; returns the edge index at which it is sampled
  task automatic start_dut_a(input int mode, input bit rep, input bit cu, input bit id,
                             output int e);
    @(negedge clk);
    mode_a  = 2'(mode);
    rep_a   = rep;
    cu_a    = cu;
    id_a    = id;
    start_a = 1'b1;
    e = cyc + 1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_drain(input int which, input int budget);
    int n;
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      #1;
      if (which == 0 && q_a.size() == 0 && dq_a.size() == 0) break;
      if (which == 1 && q_b.size() == 0 && dq_b.size() == 0) break;
      n++;
    end
    if (n >= budget) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_%0d: %0d bytes still outstanding, expected 0", which,
               (which == 0) ? q_a.size() : q_b.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int e;
    int p;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_cu", 32'(tcu_a), 32'd0);
    check("rst_id", 32'(tid_a), 32'd1);
    check("rst_data", 32'(td_a), 32'd0);
    check("rst_valid", 32'(tv_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_id_b", 32'(tid_b), 32'd1);
    rst = 1'b1;

    // 1: defaults, mode 0
    start_dut_a(0, 0, 1, 0, e);
    check("t1_cu", 32'(tcu_a), 32'd1);
    check("t1_id", 32'(tid_a), 32'd0);
    check("t1_busy", 32'(busy_a), 32'd1);
    push_frame(0, 0, e, DIV_A, N_A, N_A, 1);
    wait_drain(0, 1200);
    check("t1_busy_in_done", 32'(busy_a), 32'd1);
    @(negedge clk);
    check("t1_busy_after", 32'(busy_a), 32'd0);
    check("t1_level", 32'(tv_a), 32'(lvl_a));

    // 2: DIV=1, 20 blocks, incrementing bytes wrap at 256
    @(negedge clk);
    mode_b  = 2'd1;
    start_b = 1'b1;
    e = cyc + 1;
    @(negedge clk);
    start_b = 1'b0;
    push_frame(1, 1, e, DIV_B, N_B, N_B, 1);
    wait_drain(1, 400);
    @(negedge clk);
    check("t2_level", 32'(tv_b), 32'd0);
    check("t2_busy_after", 32'(busy_b), 32'd0);

    // 3: abort on the strobe cycle of byte 10
    start_dut_a(1, 0, 0, 1, e);
    push_frame(0, 1, e, DIV_A, N_A, 10, 0);
    wait_cyc(e + 11 * DIV_A - 1);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    #1;
    check("t3_busy", 32'(busy_a), 32'd0);
    check("t3_data_held", 32'(td_a), 32'h09);
    check("t3_level", 32'(tv_a), 32'(lvl_a));
    check("t3_pending", 32'(q_a.size()), 32'd0);
    repeat (40) @(negedge clk);
    start_dut_a(1, 0, 0, 1, e);
    push_frame(0, 1, e, DIV_A, N_A, N_A, 1);
    wait_drain(0, 1200);
    @(negedge clk);
    check("t3_restart_level", 32'(tv_a), 32'(lvl_a));

    // 4: repeat, ignored start while busy, stop via abort in the third frame
    start_dut_a(2, 1, 1, 1, e);
    p = N_A * DIV_A + 1;
    push_frame(0, 2, e, DIV_A, N_A, N_A, 1);
    push_frame(0, 2, e + p, DIV_A, N_A, N_A, 1);
    push_frame(0, 2, e + 2 * p, DIV_A, N_A, 5, 0);
    wait_cyc(e + 100);
    begin
      int ign;
      start_dut_a(0, 0, 0, 0, ign);
    end
    wait_cyc(e + 2 * p + 5 * DIV_A + 3);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    #1;
    lvl_a = lvl_a ^ 1'b1;  // 133 toggles
    check("t4_busy", 32'(busy_a), 32'd0);
    check("t4_data_held", 32'(td_a), 32'hFF);
    check("t4_level", 32'(tv_a), 32'(lvl_a));
    check("t4_pending", 32'(q_a.size() + dq_a.size()), 32'd0);
    repeat (40) @(negedge clk);

    // 5: mode 3
    start_dut_a(3, 0, 0, 0, e);
    push_frame(0, 3, e, DIV_A, N_A, N_A, 1);
    wait_drain(0, 1200);
    @(negedge clk);
    check("t5_level", 32'(tv_a), 32'(lvl_a));

    // 6: reset mid-frame
    start_dut_a(1, 0, 1, 0, e);
    push_frame(0, 1, e, DIV_A, N_A, 5, 0);
    wait_cyc(e + 5 * DIV_A + 7);
    #2 rst = 1'b0;
    #1;
    check("t6_cu", 32'(tcu_a), 32'd0);
    check("t6_id", 32'(tid_a), 32'd1);
    check("t6_data", 32'(td_a), 32'd0);
    check("t6_valid", 32'(tv_a), 32'd0);
    check("t6_busy", 32'(busy_a), 32'd0);
    check("t6_pending", 32'(q_a.size()), 32'd0);
    lvl_a = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    start_dut_a(1, 0, 1, 1, e);
    push_frame(0, 1, e, DIV_A, N_A, N_A, 1);
    wait_drain(0, 1200);
    @(negedge clk);
    check("t6_busy_after", 32'(busy_a), 32'd0);
    check("t6_level", 32'(tv_a), 32'(lvl_a));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
